// File: rtl/bcd_mod_counter_pkg.sv
// rtl/bcd_mod_counter_pkg.sv - shared digit width, time-field moduli and BCD helper
package bcd_mod_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    // Two-digit BCD of 0..99: {tens, ones}
    function automatic logic [2*DIGIT_W-1:0] bcd_of(input int n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// rtl/bcd_mod_counter_digit.sv - one BCD decade with load, inc/dec and carry/borrow
module bcd_digit
    import bcd_mod_counter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ld_i,
    input  logic [DIGIT_W-1:0] ld_val_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic [DIGIT_W-1:0] max_val_i,
    input  logic [DIGIT_W-1:0] wrap_val_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               co_o
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (ld_i) begin
            digit_d = ld_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q == max_val_i) ? '0 : digit_q + 1'b1;
        end else if (dec_i) begin
            digit_d = (digit_q == '0) ? wrap_val_i : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign co_o    = (inc_i && (digit_q == max_val_i)) || (dec_i && (digit_q == '0));

endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo-N up/down counter with preset, cascade CO and sticky Err
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int MOD_N = 24
) (
    input  logic               CP,
    input  logic               nCR,
    input  logic               EN,
    input  logic               Load,
    input  logic               UpDn,
    input  logic [DIGIT_W-1:0] LdH,
    input  logic [DIGIT_W-1:0] LdL,
    output logic [DIGIT_W-1:0] CntH,
    output logic [DIGIT_W-1:0] CntL,
    output logic               CO,
    output logic               Err
);

    if ((MOD_N < 2) || (MOD_N > 100)) begin : g_bad_mod
        $error("bcd_mod_counter: MOD_N=%0d outside legal range 2..100", MOD_N);
    end

    localparam logic [2*DIGIT_W-1:0] TERM = bcd_of(MOD_N - 1);

    logic [2*DIGIT_W-1:0] cnt;
    logic                 valid, ld_ok, at_term, at_zero;
    logic                 reload, step_up, step_dn;
    logic [2*DIGIT_W-1:0] reload_val;
    logic                 err_q, err_d;
    logic                 lo_co, hi_co;

    assign cnt     = {CntH, CntL};
    assign valid   = (CntH <= DIGIT_MAX) && (CntL <= DIGIT_MAX) && (cnt <= TERM);
    assign ld_ok   = (LdH <= DIGIT_MAX) && (LdL <= DIGIT_MAX) && ({LdH, LdL} <= TERM);
    assign at_term = (cnt == TERM);
    assign at_zero = (cnt == '0);

    always_comb begin
        reload     = 1'b0;
        reload_val = '0;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        err_d      = err_q;
        if (Load) begin
            reload     = 1'b1;
            reload_val = ld_ok ? {LdH, LdL} : '0;
            err_d      = !ld_ok;
        end else if (EN) begin
            if (!valid) begin
                reload = 1'b1;
                err_d  = 1'b1;
            end else if (UpDn) begin
                reload  = at_term;
                step_up = !at_term;
            end else begin
                reload     = at_zero;
                reload_val = TERM;
                step_dn    = !at_zero;
            end
        end
    end

    bcd_digit u_lo (
        .clk_i     (CP),
        .rst_ni    (nCR),
        .ld_i      (reload),
        .ld_val_i  (reload_val[DIGIT_W-1:0]),
        .inc_i     (step_up),
        .dec_i     (step_dn),
        .max_val_i (DIGIT_MAX),
        .wrap_val_i(DIGIT_MAX),
        .digit_o   (CntL),
        .co_o      (lo_co)
    );

    // A tens roll-over can only come from 99, which is always the term value, so it rides the reload
    bcd_digit u_hi (
        .clk_i     (CP),
        .rst_ni    (nCR),
        .ld_i      (reload || hi_co),
        .ld_val_i  (reload_val[2*DIGIT_W-1:DIGIT_W]),
        .inc_i     (lo_co && step_up),
        .dec_i     (lo_co && step_dn),
        .max_val_i (DIGIT_MAX),
        .wrap_val_i(DIGIT_MAX),
        .digit_o   (CntH),
        .co_o      (hi_co)
    );

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err = err_q;
    assign CO  = EN && !Load && valid && (UpDn ? at_term : at_zero);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - directed self-checking bench for bcd_mod_counter and a 60/60/24 chain
module tb_bcd_mod_counter;

    logic       CP = 1'b0;
    logic       nCR;
    logic       en, load, up;
    logic [3:0] ldh, ldl, cnth, cntl;
    logic       co, err;

    logic       c_en, c_load, c_up;
    logic [3:0] s_ldh, s_ldl, m_ldh, m_ldl, h_ldh, h_ldl;
    logic [3:0] s_h, s_l, m_h, m_l, h_h, h_l;
    logic       s_co, m_co, h_co, s_err, m_err, h_err;

    int checks = 0;
    int errors = 0;

    always #5 CP = ~CP;

    bcd_mod_counter #(.MOD_N(24)) dut (
        .CP(CP), .nCR(nCR), .EN(en), .Load(load), .UpDn(up), .LdH(ldh), .LdL(ldl),
        .CntH(cnth), .CntL(cntl), .CO(co), .Err(err)
    );

    bcd_mod_counter #(.MOD_N(60)) u_sec (
        .CP(CP), .nCR(nCR), .EN(c_en), .Load(c_load), .UpDn(c_up), .LdH(s_ldh), .LdL(s_ldl),
        .CntH(s_h), .CntL(s_l), .CO(s_co), .Err(s_err)
    );

    bcd_mod_counter #(.MOD_N(60)) u_min (
        .CP(CP), .nCR(nCR), .EN(s_co), .Load(c_load), .UpDn(c_up), .LdH(m_ldh), .LdL(m_ldl),
        .CntH(m_h), .CntL(m_l), .CO(m_co), .Err(m_err)
    );

    bcd_mod_counter #(.MOD_N(24)) u_hr (
        .CP(CP), .nCR(nCR), .EN(m_co), .Load(c_load), .UpDn(c_up), .LdH(h_ldh), .LdL(h_ldl),
        .CntH(h_h), .CntL(h_l), .CO(h_co), .Err(h_err)
    );

    typedef struct {
        string      name;
        logic       load, en, up;
        logic [3:0] ldh, ldl;
        logic       exp_co;
        logic [7:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    initial begin
        vecs.push_back('{"ld_25_bad",    1, 0, 1, 4'h2, 4'h5, 0, 8'h00, 1});
        vecs.push_back('{"ld_1A_bad",    1, 0, 1, 4'h1, 4'hA, 0, 8'h00, 1});
        vecs.push_back('{"ld_17_ok",     1, 0, 1, 4'h1, 4'h7, 0, 8'h17, 0});
        vecs.push_back('{"up_17",        0, 1, 1, 4'h0, 4'h0, 0, 8'h18, 0});
        vecs.push_back('{"hold_18",      0, 0, 1, 4'h0, 4'h0, 0, 8'h18, 0});
        vecs.push_back('{"dn_18",        0, 1, 0, 4'h0, 4'h0, 0, 8'h17, 0});
        vecs.push_back('{"ld_23_en",     1, 1, 1, 4'h2, 4'h3, 0, 8'h23, 0});
        vecs.push_back('{"up_wrap_23",   0, 1, 1, 4'h0, 4'h0, 1, 8'h00, 0});
        vecs.push_back('{"dn_wrap_00",   0, 1, 0, 4'h0, 4'h0, 1, 8'h23, 0});
        vecs.push_back('{"dn_23",        0, 1, 0, 4'h0, 4'h0, 0, 8'h22, 0});
        vecs.push_back('{"ld_09",        1, 0, 0, 4'h0, 4'h9, 0, 8'h09, 0});
        vecs.push_back('{"up_09_carry",  0, 1, 1, 4'h0, 4'h0, 0, 8'h10, 0});
        vecs.push_back('{"dn_10_borrow", 0, 1, 0, 4'h0, 4'h0, 0, 8'h09, 0});
        vecs.push_back('{"ld_99_range",  1, 0, 1, 4'h9, 4'h9, 0, 8'h00, 1});
        vecs.push_back('{"up_keeps_err", 0, 1, 1, 4'h0, 4'h0, 0, 8'h01, 1});
        vecs.push_back('{"ld_00_clr",    1, 0, 1, 4'h0, 4'h0, 0, 8'h00, 0});

        nCR = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1; ldh = '0; ldl = '0;
        c_en = 1'b0; c_load = 1'b0; c_up = 1'b1;
        s_ldh = '0; s_ldl = '0; m_ldh = '0; m_ldl = '0; h_ldh = '0; h_ldl = '0;
        #2;
        check("reset_cnt", {cnth, cntl}, 8'h00);
        check("reset_err", err, 1'b0);
        check("reset_co", co, 1'b0);
        @(negedge CP);
        nCR = 1'b1;
        step();

        foreach (vecs[i]) begin
            load = vecs[i].load; en = vecs[i].en; up = vecs[i].up;
            ldh = vecs[i].ldh; ldl = vecs[i].ldl;
            #1;
            check({vecs[i].name, "_co"}, co, vecs[i].exp_co);
            step();
            check({vecs[i].name, "_cnt"}, {cnth, cntl}, vecs[i].exp_cnt);
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
        end

        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            check($sformatf("mod24_co_%0d", i), co, (i == 23));
            step();
            check($sformatf("mod24_cnt_%0d", i), {cnth, cntl}, to_bcd((i + 1) % 24));
        end

        c_load = 1'b1; s_ldh = 4'h0; s_ldl = 4'h0; m_ldh = 4'h5; m_ldl = 4'h9; h_ldh = 4'h2; h_ldl = 4'h3;
        step();
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b0;
        #1;
        check("sec_dn_co_at_00", s_co, 1'b1);
        step();
        check("sec_dn_wrap_59", {s_h, s_l}, 8'h59);
        check("sec_dn_co_at_59", s_co, 1'b0);
        step();
        check("sec_dn_58", {s_h, s_l}, 8'h58);
        c_en = 1'b0; c_load = 1'b1; s_ldh = 4'h1; s_ldl = 4'h0;
        step();
        c_load = 1'b0; c_en = 1'b1;
        step();
        check("sec_dn_10_borrow", {s_h, s_l}, 8'h09);

        c_en = 1'b0; c_load = 1'b1; c_up = 1'b1;
        s_ldh = 4'h5; s_ldl = 4'h8; m_ldh = 4'h5; m_ldl = 4'h9; h_ldh = 4'h2; h_ldl = 4'h3;
        step();
        c_load = 1'b0;
        check("chain_preset", {h_h, h_l, m_h, m_l, s_h, s_l}, 24'h235958);
        c_en = 1'b1;
        #1;
        check("chain_hco_pre", h_co, 1'b0);
        step();
        check("chain_sec_59", {h_h, h_l, m_h, m_l, s_h, s_l}, 24'h235959);
        check("chain_hco_hi", h_co, 1'b1);
        step();
        check("chain_wrap", {h_h, h_l, m_h, m_l, s_h, s_l}, 24'h000000);
        check("chain_hco_lo", h_co, 1'b0);
        check("chain_err", {s_err, m_err, h_err}, 3'b000);
        c_en = 1'b0;

        en = 1'b1; up = 1'b1; load = 1'b0;
        @(negedge CP);
        force dut.u_hi.digit_q = 4'h3;
        force dut.u_lo.digit_q = 4'hC;
        #1;
        check("bad_state_co", co, 1'b0);
        step();
        check("bad_state_err", err, 1'b1);
        release dut.u_hi.digit_q;
        release dut.u_lo.digit_q;
        step();
        check("bad_state_recover", (cntl <= 4'd9) && ({cnth, cntl} <= 8'h23), 1'b1);
        for (int i = 0; i < 30; i++) begin
            step();
            check($sformatf("err_sticky_%0d", i), err, 1'b1);
        end

        #4;
        nCR = 1'b0;
        #1;
        check("async_clr_cnt", {cnth, cntl}, 8'h00);
        check("async_clr_err", err, 1'b0);
        #1;
        nCR = 1'b1;
        step();
        check("resume_cnt", {cnth, cntl}, 8'h01);
        check("resume_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
